line_buf_ctrl: RTL and testbench
================================

LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 64, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, buffer entries; power of two, 4..256.
REQ-003 SHALL have parameter PRIME, default 3, entries required before the first read is issued; range 1..DEPTH.
REQ-004 SHALL have ports (name direction width meaning):
  clk  input  1  clock, rising edge
  rst  input  1  reset, asynchronous, active-high
  en  input  1  block enable; low = synchronous clear of control state
  wr_valid  input  1  write request
  wr_ready  output  1  buffer can accept a write
  wr_data  input  DATA_W  write word
  stall  input  1  hold off new reads (consumer busy)
  rd_valid  output  1  rd_data holds a valid word
  rd_ready  input  1  consumer accepts rd_data
  rd_data  output  DATA_W  read word, registered
  count  output  clog2(DEPTH+1)  entries stored, excluding the word in rd_data
  primed  output  1  PRIME threshold has been reached since last clear
  overflow_err  output  1  sticky: write attempted while wr_ready low

Function
REQ-005 SHALL operate as a circular buffer: wr_ptr/rd_ptr width clog2(DEPTH), each wrapping DEPTH-1 -> 0.
REQ-006 SHALL drive wr_ready = en && (count < DEPTH), combinational from registered count only.
REQ-007 SHALL accept a push when wr_valid && wr_ready: write wr_data at wr_ptr, increment wr_ptr.
REQ-008 SHALL set primed one cycle after count first reaches >= PRIME; primed then holds until en low or rst, and does not clear when count returns to 0.
REQ-009 SHALL pop when primed && count != 0 && !stall && (!rd_valid || rd_ready): load mem[rd_ptr] into rd_data, increment rd_ptr, set rd_valid.
REQ-010 SHALL clear rd_valid when rd_ready && rd_valid && no pop; otherwise hold rd_valid and rd_data unchanged.
REQ-011 SHALL give write-to-rd_valid latency of exactly 1 cycle for any pop following a push once primed and the buffer was empty.
REQ-012 SHALL leave count unchanged on simultaneous push and pop, +1 on push only, -1 on pop only; count never exceeds DEPTH or goes below 0.
REQ-013 SHALL never pop the slot being written in the same cycle (pop requires count != 0 before the edge).
REQ-014 SHALL not affect an already-valid rd_data/rd_valid when stall asserts; stall only blocks new pops.
REQ-015 SHALL set overflow_err when en && wr_valid && !wr_ready; held until en low or rst.
REQ-016 SHALL, while en is low, synchronously clear wr_ptr, rd_ptr, count, primed, rd_valid, overflow_err; rd_data and memory contents are held; wr_valid is ignored.
REQ-017 SHALL sustain one push and one pop per cycle in steady state (full throughput).

Reset
REQ-018 SHALL on rst asynchronously clear wr_ptr, rd_ptr, count, primed, rd_valid, overflow_err and rd_data to 0.
REQ-019 SHALL on rst mid-transfer discard all stored entries; first post-reset read again waits for PRIME writes.
REQ-020 SHALL not reset memory array contents.

Structure
REQ-021 SHALL place default DATA_W/DEPTH/PRIME constants and the clog2 function in shared package conv_acc_pkg.
REQ-022 SHALL instantiate one sub-module sdp_ram (DATA_W x DEPTH, sync write port, sync read port with read enable = pop).
REQ-023 SHALL keep all pointer/count/handshake logic in line_buf_ctrl; no logic in sdp_ram beyond storage.

Verification (DEPTH=8, PRIME=3, DATA_W=64)
REQ-024 Priming: push 0xA0,0xA1 with rd_ready=1 -> rd_valid stays 0, count=2; push 0xA2 -> primed after 1 cycle, then rd_data=0xA0, 0xA1, 0xA2 on consecutive cycles, count ends 0.
REQ-025 Full/overflow: rd_ready=0, push 9 words -> wr_ready=0 after count=8 (with one word held in rd_data), 9th+ attempt sets overflow_err=1, stored data intact.
REQ-026 Wrap-around: stream 20 words 0x00..0x13 with rd_ready=1 -> output order 0x00..0x13, no gaps after priming, count never >3.
REQ-027 Stall/backpressure: primed, count=4, assert stall 3 cycles with rd_ready=1 -> held word consumed, rd_valid=0 during stall, count stays 4; release -> pops resume in order.
REQ-028 Clear: mid-stream drop en 1 cycle -> count=0, primed=0, rd_valid=0, overflow_err=0; next 2 pushes produce no rd_valid.
REQ-029 Async reset: assert rst between clock edges with count=5 -> all outputs 0 immediately, wr_ready=1 after release with en=1.

Source files
------------

// File: rtl/conv_acc_pkg.sv
// Shared constants and helpers for the convolution accelerator datapath blocks.
package conv_acc_pkg;

  localparam int LB_DATA_W = 64;
  localparam int LB_DEPTH  = 8;
  localparam int LB_PRIME  = 3;

  // Ceiling log2, usable in parameter expressions; clog2(1) == 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port storage: synchronous write port, registered read port with read enable.
module sdp_ram
  import conv_acc_pkg::*;
#(
  parameter int DATA_W = LB_DATA_W,
  parameter int DEPTH  = LB_DEPTH,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: the array has no reset so it maps onto RAM macros/LUTRAM; only the
  // read register is reset. Sequential state is always written with <=.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/line_buf_ctrl.sv
// Line buffer controller: primed circular buffer with a registered read stage,
// sticky overflow flag and a synchronous clear through en.
module line_buf_ctrl
  import conv_acc_pkg::*;
#(
  parameter int DATA_W = LB_DATA_W,
  parameter int DEPTH  = LB_DEPTH,
  parameter int PRIME  = LB_PRIME,
  localparam int AW    = clog2(DEPTH),
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              stall,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [CW-1:0]     count,
  output logic              primed,
  output logic              overflow_err
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] PRIME_C = CW'(PRIME);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          primed_q, primed_d;
  logic          rd_valid_q, rd_valid_d;
  logic          overflow_q, overflow_d;
  logic          push, pop;

  assign wr_ready = en && (count_q < DEPTH_C);
  assign push     = wr_valid && wr_ready;
  // count_q != 0 guarantees the read slot was written on an earlier edge.
  assign pop      = en && primed_q && (count_q != '0) && !stall &&
                    (!rd_valid_q || rd_ready);

  // NOTE: every next-state signal gets its default first so no latch is inferred.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    primed_d   = primed_q;
    rd_valid_d = rd_valid_q;
    overflow_d = overflow_q;
    if (!en) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      primed_d   = 1'b0;
      rd_valid_d = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (pop)                          rd_valid_d = 1'b1;
      else if (rd_ready && rd_valid_q)  rd_valid_d = 1'b0;
      if (wr_valid && !wr_ready)        overflow_d = 1'b1;
      if (count_d >= PRIME_C)           primed_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      primed_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      primed_q   <= primed_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

  sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data),
    .rd_en_i   (pop),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign primed       = primed_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Self-checking bench for line_buf_ctrl: priming vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_line_buf_ctrl;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 8;
  localparam int PRIME  = 3;

  logic              clk, rst, en, wr_valid, stall, rd_ready;
  logic              wr_ready, rd_valid, primed, overflow_err;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic [3:0]        count;

  line_buf_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PRIME(PRIME)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .stall        (stall),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .count        (count),
    .primed       (primed),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stored words as a queue plus the output register state.
  logic [63:0] mq[$];
  bit          m_primed, m_rv, m_ovf;
  logic [63:0] m_rd;

  task automatic model_reset();
    mq.delete();
    m_primed = 0; m_rv = 0; m_ovf = 0; m_rd = '0;
  endtask

  task automatic model_step();
    int sz;
    bit rdy, do_pop;
    sz  = mq.size();
    rdy = en && (sz < DEPTH);
    if (!en) begin
      mq.delete();
      m_primed = 0; m_rv = 0; m_ovf = 0;
    end else begin
      do_pop = m_primed && sz != 0 && !stall && (!m_rv || rd_ready);
      if (wr_valid && !rdy) m_ovf = 1;
      if (do_pop) begin
        m_rd = mq.pop_front();
        m_rv = 1;
      end else if (rd_ready && m_rv) m_rv = 0;
      if (wr_valid && rdy) mq.push_back(wr_data);
      if (mq.size() >= PRIME) m_primed = 1;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".rd_valid"}, rd_valid, m_rv);
    check({tag, ".rd_data"},  rd_data, m_rd);
    check({tag, ".count"},    count, 64'(mq.size()));
    check({tag, ".primed"},   primed, m_primed);
    check({tag, ".overflow"}, overflow_err, m_ovf);
    check({tag, ".wr_ready"}, wr_ready, en && (mq.size() < DEPTH));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d);
    wr_valid = v;
    wr_data  = d;
  endtask

  typedef struct {
    logic        wv;
    logic [63:0] wd;
    logic        exp_rv;
    logic [63:0] exp_rd;
    int          exp_cnt;
    logic        exp_pr;
  } vec_t;

  vec_t        vecs[10];
  logic [63:0] got[$];
  int          max_cnt, first_v, last_v, nvalid;

  initial begin
    rst = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_data = '0; stall = 1'b0; rd_ready = 1'b0;
    model_reset();
    #12;
    check("async_reset.count", count, 0);
    en = 1'b1;
    apply_reset();
    check_model("reset");

    // Priming with rd_ready high, then the single-entry one-cycle latency case.
    vecs[0] = '{1'b1, 64'hA0, 1'b0, 64'h00, 1, 1'b0};
    vecs[1] = '{1'b1, 64'hA1, 1'b0, 64'h00, 2, 1'b0};
    vecs[2] = '{1'b1, 64'hA2, 1'b0, 64'h00, 3, 1'b1};
    vecs[3] = '{1'b0, 64'h00, 1'b1, 64'hA0, 2, 1'b1};
    vecs[4] = '{1'b0, 64'h00, 1'b1, 64'hA1, 1, 1'b1};
    vecs[5] = '{1'b0, 64'h00, 1'b1, 64'hA2, 0, 1'b1};
    vecs[6] = '{1'b0, 64'h00, 1'b0, 64'hA2, 0, 1'b1};
    vecs[7] = '{1'b1, 64'hB0, 1'b0, 64'hA2, 1, 1'b1};
    vecs[8] = '{1'b0, 64'h00, 1'b1, 64'hB0, 0, 1'b1};
    vecs[9] = '{1'b0, 64'h00, 1'b0, 64'hB0, 0, 1'b1};
    rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].wv, vecs[i].wd);
      step();
      check($sformatf("prime[%0d].rd_valid", i), rd_valid, vecs[i].exp_rv);
      check($sformatf("prime[%0d].rd_data", i),  rd_data, vecs[i].exp_rd);
      check($sformatf("prime[%0d].count", i),    count, 64'(vecs[i].exp_cnt));
      check($sformatf("prime[%0d].primed", i),   primed, vecs[i].exp_pr);
      check($sformatf("prime[%0d].wr_ready", i), wr_ready, 1'b1);
    end
    drive(0, 0);

    // Full buffer and overflow with the consumer blocked; data must survive.
    apply_reset();
    rd_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(1, 64'hC0 + 64'(i));
      step();
      check_model("full");
    end
    check("full.count", count, 8);
    check("full.wr_ready", wr_ready, 0);
    check("full.rd_valid", rd_valid, 1);
    check("full.rd_data", rd_data, 64'hC0);
    drive(1, 64'hCF);
    step();
    check_model("ovf");
    check("ovf.overflow", overflow_err, 1);
    check("ovf.count", count, 8);
    drive(0, 0);
    rd_ready = 1'b1;
    got.delete();
    for (int k = 0; k < 12; k++) begin
      if (rd_valid) got.push_back(rd_data);
      step();
      check_model("drain");
    end
    check("drain.n", 64'(got.size()), 9);
    for (int k = 0; k < got.size(); k++)
      check($sformatf("drain[%0d]", k), got[k], 64'hC0 + 64'(k));

    // Synchronous clear through en mid-stream, with overflow still sticky.
    for (int i = 0; i < 4; i++) begin
      drive(1, 64'hD0 + 64'(i));
      step();
      check_model("pre_clr");
    end
    drive(0, 0);
    en = 1'b0;
    step();
    check_model("clr");
    check("clr.count", count, 0);
    check("clr.primed", primed, 0);
    check("clr.rd_valid", rd_valid, 0);
    check("clr.overflow", overflow_err, 0);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(i < 2, 64'hE0 + 64'(i));
      step();
      check_model("post_clr");
      check($sformatf("post_clr[%0d].rd_valid", i), rd_valid, 0);
    end
    drive(0, 0);

    // Continuous stream: full throughput, in-order, count bounded by PRIME.
    apply_reset();
    rd_ready = 1'b1;
    got.delete();
    max_cnt = 0; first_v = -1; last_v = -1; nvalid = 0;
    for (int c = 0; c < 30; c++) begin
      drive(c < 20, 64'(c));
      step();
      check_model("wrap");
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (rd_valid) begin
        got.push_back(rd_data);
        if (first_v < 0) first_v = c;
        last_v = c;
        nvalid++;
      end
    end
    drive(0, 0);
    check("wrap.n", 64'(got.size()), 20);
    check("wrap.no_gap", 64'(last_v - first_v + 1), 64'(nvalid));
    check("wrap.max_cnt_le3", max_cnt <= 3, 1);
    for (int k = 0; k < got.size(); k++)
      check($sformatf("wrap[%0d]", k), got[k], 64'(k));

    // Stall: held word consumed, no new pops, count frozen, then resume in order.
    apply_reset();
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 64'hF0 + 64'(i));
      step();
      check_model("stall_fill");
    end
    drive(0, 0);
    check("stall.count0", count, 4);
    check("stall.held", rd_data, 64'hF0);
    rd_ready = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_model("stall");
      check($sformatf("stall[%0d].rd_valid", i), rd_valid, 0);
      check($sformatf("stall[%0d].count", i), count, 4);
    end
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_model("resume");
      check($sformatf("resume[%0d].rd_data", i), rd_data, 64'hF1 + 64'(i));
    end

    // Asynchronous reset between edges with five entries stored.
    apply_reset();
    rd_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 64'h50 + 64'(i));
      step();
      check_model("arst_fill");
    end
    drive(0, 0);
    check("arst.count5", count, 5);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("arst.count", count, 0);
    check("arst.rd_valid", rd_valid, 0);
    check("arst.rd_data", rd_data, 0);
    check("arst.primed", primed, 0);
    check("arst.overflow", overflow_err, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("arst.wr_ready", wr_ready, 1);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(i < 2, 64'h60 + 64'(i));
      step();
      check_model("arst_reprime");
    end
    drive(0, 0);

    // Randomized traffic against the reference model.
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      en       = ($urandom_range(0, 99) >= 3);
      wr_valid = ($urandom_range(0, 99) < 60);
      wr_data  = {$urandom, $urandom};
      stall    = ($urandom_range(0, 99) < 20);
      rd_ready = ($urandom_range(0, 99) < 65);
      step();
      check_model($sformatf("rand[%0d]", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
